// File: rtl/jt12_slotcnt.sv
// JT12 operator/channel slot sequencer: {op,ch} slot counter, successor, markers and delayed copy.
// Optional illegal-state checker enabled by defining JT12_SLOTCNT_CHK_EN.
module jt12_slotcnt #(
  parameter int NUM_CH = 6,
  parameter int NUM_OP = 4,
  parameter int DLY    = 2
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic       resync,
  output logic [4:0] slot,
  output logic [4:0] slot_nx,
  output logic [2:0] ch_lin,
  output logic [1:0] op,
  output logic       zero,
  output logic       last,
  output logic       frame,
  output logic [4:0] slot_dly,
  output logic       err
);

  localparam logic [2:0] LAST_CH = (NUM_CH == 6) ? 3'd6 : 3'd2;
  localparam logic [1:0] OP_LAST = (NUM_OP == 4) ? 2'd3 : 2'd1;
  localparam logic [4:0] LAST_SLOT = {OP_LAST, LAST_CH};

  logic [4:0] slot_r;
  logic [2:0] ch_lin_r;
  logic       zero_r;
  logic       last_r;
  logic       frame_r;
  logic       pending_r;
  logic [2:0] ch_s;
  logic [1:0] op_s;
  logic [2:0] ch_nx_s;
  logic [1:0] op_nx_s;
  logic       bad_s;
  logic [4:0] slot_ld_s;

  // Channel codes 3 and 7 are holes in the 6-channel bank, so the low field is not a plain counter.
  function automatic logic [2:0] lin_idx(input logic [2:0] c);
    if (NUM_CH == 6) lin_idx = {1'b0, c[1:0]} + (c[2] ? 3'd3 : 3'd0);
    else             lin_idx = {1'b0, c[1:0]};
  endfunction

  assign ch_s = slot_r[2:0];
  assign op_s = slot_r[4:3];

  // Successor slot: step channel code, skip the hole after 2, bump operator after the last channel.
  always_comb begin
    ch_nx_s = 3'd0;
    op_nx_s = op_s;
    if (ch_s == LAST_CH) begin
      ch_nx_s = 3'd0;
      op_nx_s = (op_s == OP_LAST) ? 2'd0 : op_s + 2'd1;
    end else if (ch_s == 3'd2) begin
      ch_nx_s = 3'd4;
      op_nx_s = op_s;
    end else begin
      ch_nx_s = ch_s + 3'd1;
      op_nx_s = op_s;
    end
  end

  assign slot_nx = {op_nx_s, ch_nx_s};

`ifdef JT12_SLOTCNT_CHK_EN
  logic err_r;

  function automatic logic illegal(input logic [4:0] s);
    illegal = (s[1:0] == 2'd3) ||
              ((NUM_CH == 3) && (s[2:0] > 3'd2)) ||
              ({1'b0, s[4:3]} >= 3'(NUM_OP));
  endfunction

  assign bad_s = illegal(slot_r);

  // Sticky error flag, sampled every clock regardless of enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_r <= 1'b0;
    else     err_r <= err_r | bad_s;
  end

  assign err = err_r;
`else
  assign bad_s = 1'b0;
  assign err   = 1'b0;
`endif

  assign slot_ld_s = (resync || pending_r || bad_s) ? 5'd0 : slot_nx;

  // Slot state and the markers derived from the value being loaded, so they align with slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_r    <= 5'd0;
      ch_lin_r  <= 3'd0;
      zero_r    <= 1'b1;
      last_r    <= 1'b0;
      frame_r   <= 1'b0;
      pending_r <= 1'b0;
    end else if (cen) begin
      slot_r    <= slot_ld_s;
      ch_lin_r  <= lin_idx(slot_ld_s[2:0]);
      zero_r    <= (slot_ld_s == 5'd0);
      last_r    <= (slot_ld_s == LAST_SLOT);
      frame_r   <= (slot_ld_s == 5'd0);
      pending_r <= 1'b0;
    end else begin
      frame_r   <= 1'b0;
      pending_r <= pending_r | resync;
    end
  end

  assign slot   = slot_r;
  assign op     = slot_r[4:3];
  assign ch_lin = ch_lin_r;
  assign zero   = zero_r;
  assign last   = last_r;
  assign frame  = frame_r;

  generate
    if (DLY > 0) begin : g_dly
      logic [4:0] dly_r [DLY];

      // Shift pipe advanced only with the slot itself; resync deliberately leaves it alone.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DLY; i++) dly_r[i] <= 5'd0;
        end else if (cen) begin
          dly_r[0] <= slot_r;
          for (int i = 1; i < DLY; i++) dly_r[i] <= dly_r[i-1];
        end else begin
          for (int i = 0; i < DLY; i++) dly_r[i] <= dly_r[i];
        end
      end

      assign slot_dly = dly_r[DLY-1];
    end else begin : g_nodly
      assign slot_dly = slot_r;
    end
  endgenerate

endmodule
